// File: rtl/roi_color_classifier.sv
// roi_color_classifier: classifies ROI pixels by dominant channel, counts each class per frame
// and publishes the dominant colour plus the three counts at every frame boundary.
module roi_color_classifier #(
  parameter int ROI_X0     = 140,
  parameter int ROI_Y0     = 100,
  parameter int ROI_W      = 40,
  parameter int ROI_H      = 40,
  parameter int DOM_MARGIN = 16,
  parameter int MIN_PIXELS = 400,
  parameter int CNT_W      = 12
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             pixel_valid,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic [7:0]       pixel_r8,
  input  logic [7:0]       pixel_g8,
  input  logic [7:0]       pixel_b8,
  output logic             in_roi,
  output logic [1:0]       color_code,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count,
  output logic             result_valid
);
  typedef enum logic [1:0] {WAIT_FIRST, ACCUM, DECIDE, PUBLISH} state_t;
  localparam logic [10:0] X0 = 11'(ROI_X0);
  localparam logic [10:0] X1 = 11'(ROI_X0 + ROI_W);
  localparam logic [10:0] Y0 = 11'(ROI_Y0);
  localparam logic [10:0] Y1 = 11'(ROI_Y0 + ROI_H);
  localparam logic [8:0]  M  = 9'(DOM_MARGIN);
  state_t state;
  logic [8:0] r, g, b;
  logic hit, is_r, is_g, is_b, fs_d1, inc_r, inc_g, inc_b;
  logic [1:0] cls, cls_c, win_code, dec_code;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, snap_r, snap_g, snap_b, win_cnt;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? {{(CNT_W-1){1'b0}}, inc} : (inc && c != '1) ? c + 1'b1 : c;
  endfunction
  always_comb begin
    r = {1'b0, pixel_r8};
    g = {1'b0, pixel_g8};
    b = {1'b0, pixel_b8};
    hit = pixel_valid && {1'b0, pixel_x} >= X0 && {1'b0, pixel_x} < X1
                      && {1'b0, pixel_y} >= Y0 && {1'b0, pixel_y} < Y1;
    is_r = r >= g + M && r >= b + M;
    is_g = g >= r + M && g >= b + M;
    is_b = b >= r + M && b >= g + M;
    cls_c = is_r ? 2'd1 : is_g ? 2'd2 : is_b ? 2'd3 : 2'd0;
    inc_r = in_roi && cls == 2'd1;
    inc_g = in_roi && cls == 2'd2;
    inc_b = in_roi && cls == 2'd3;
    win_code = (snap_r >= snap_g && snap_r >= snap_b) ? 2'd1 : (snap_g >= snap_b) ? 2'd2 : 2'd3;
    win_cnt = win_code == 2'd1 ? snap_r : win_code == 2'd2 ? snap_g : snap_b;
    dec_code = (win_cnt == '0 || int'(win_cnt) < MIN_PIXELS) ? 2'd0 : win_code;
  end
  // Outputs load on entry to PUBLISH so result_valid lands three cycles after frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_FIRST;
      in_roi <= 1'b0;
      cls <= 2'd0;
      fs_d1 <= 1'b0;
      {cnt_r, cnt_g, cnt_b, snap_r, snap_g, snap_b} <= '0;
      {red_count, green_count, blue_count} <= '0;
      color_code <= 2'd0;
      result_valid <= 1'b0;
    end else begin
      in_roi <= hit;
      cls <= cls_c;
      fs_d1 <= frame_start;
      cnt_r <= bump(cnt_r, inc_r, fs_d1);
      cnt_g <= bump(cnt_g, inc_g, fs_d1);
      cnt_b <= bump(cnt_b, inc_b, fs_d1);
      if (fs_d1) begin
        snap_r <= cnt_r;
        snap_g <= cnt_g;
        snap_b <= cnt_b;
      end
      result_valid <= 1'b0;
      case (state)
        WAIT_FIRST: if (fs_d1) state <= ACCUM;
        ACCUM:      if (fs_d1) state <= DECIDE;
        DECIDE: begin
          color_code <= dec_code;
          red_count <= snap_r;
          green_count <= snap_g;
          blue_count <= snap_b;
          result_valid <= 1'b1;
          state <= PUBLISH;
        end
        PUBLISH:    state <= ACCUM;
        default:    state <= WAIT_FIRST;
      endcase
    end
  end
endmodule

// File: tb/tb_roi_color_classifier.sv
// tb_roi_color_classifier: directed frames against the colour classifier, including 8-bit counter variants.
module tb_roi_color_classifier;
  logic clk = 1'b0, reset, frame_start, pixel_valid;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] pixel_r8, pixel_g8, pixel_b8;
  logic in_roi, result_valid, in_roi8, rv8, in_roi8m, rv8m;
  logic [1:0] color_code, code8, code8m;
  logic [11:0] red_count, green_count, blue_count;
  logic [7:0] red8, green8, blue8, red8m, green8m, blue8m;
  int checks = 0, passed = 0, roi_hits = 0, rv_seen = 0;

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (in_roi) roi_hits++;
    if (result_valid) rv_seen++;
  end

  roi_color_classifier dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_r8(pixel_r8), .pixel_g8(pixel_g8), .pixel_b8(pixel_b8),
    .in_roi(in_roi), .color_code(color_code), .red_count(red_count), .green_count(green_count),
    .blue_count(blue_count), .result_valid(result_valid));

  roi_color_classifier #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_r8(pixel_r8), .pixel_g8(pixel_g8), .pixel_b8(pixel_b8),
    .in_roi(in_roi8), .color_code(code8), .red_count(red8), .green_count(green8),
    .blue_count(blue8), .result_valid(rv8));

  roi_color_classifier #(.CNT_W(8), .MIN_PIXELS(200)) dut8m (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_r8(pixel_r8), .pixel_g8(pixel_g8), .pixel_b8(pixel_b8),
    .in_roi(in_roi8m), .color_code(code8m), .red_count(red8m), .green_count(green8m),
    .blue_count(blue8m), .result_valid(rv8m));

  task drive(input logic fs, input logic v, input int x, input int y, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge clk);
    #1;
    frame_start = fs;
    pixel_valid = v;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pixel_r8 = r;
    pixel_g8 = g;
    pixel_b8 = b;
  endtask

  task idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, 8'd0);
  endtask

  task roi_px(input int start, input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = start; i < start + n; i++) drive(1'b0, 1'b1, 140 + i % 40, 100 + i / 40, r, g, b);
  endtask

  // Closes the current frame (optionally with a pixel riding on frame_start) and checks the publish.
  task frame_end(input string tag, input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                 input logic [1:0] ec, input int er, input int eg, input int eb);
    logic [4:1] seen;
    drive(1'b1, v, 140, 100, r, g, b);
    idle(1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      seen[k] = result_valid;
    end
    checks++; if (seen !== 4'b0100) $display("FAIL %s result_valid N+1..N+4 got %b exp 0100", tag, {seen[1], seen[2], seen[3], seen[4]}); else passed++;
    checks++; if (color_code !== ec) $display("FAIL %s color_code got %0d exp %0d", tag, color_code, ec); else passed++;
    checks++; if (red_count !== 12'(er)) $display("FAIL %s red_count got %0d exp %0d", tag, red_count, er); else passed++;
    checks++; if (green_count !== 12'(eg)) $display("FAIL %s green_count got %0d exp %0d", tag, green_count, eg); else passed++;
    checks++; if (blue_count !== 12'(eb)) $display("FAIL %s blue_count got %0d exp %0d", tag, blue_count, eb); else passed++;
  endtask

  task test_reset;
    reset = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    {pixel_r8, pixel_g8, pixel_b8} = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_roi !== 1'b0) $display("FAIL reset in_roi got %b exp 0", in_roi); else passed++;
    checks++; if (color_code !== 2'd0) $display("FAIL reset color_code got %0d exp 0", color_code); else passed++;
    checks++; if (red_count !== 12'd0) $display("FAIL reset red_count got %0d exp 0", red_count); else passed++;
    checks++; if (green_count !== 12'd0) $display("FAIL reset green_count got %0d exp 0", green_count); else passed++;
    checks++; if (blue_count !== 12'd0) $display("FAIL reset blue_count got %0d exp 0", blue_count); else passed++;
    checks++; if (result_valid !== 1'b0) $display("FAIL reset result_valid got %b exp 0", result_valid); else passed++;
  endtask

  task test_partial_first;
    rv_seen = 0;
    drive(1'b1, 1'b0, 0, 0, 8'd0, 8'd0, 8'd0);
    roi_px(0, 1600, 8'd200, 8'd40, 8'd40);
    idle(6);
    checks++; if (rv_seen !== 0) $display("FAIL partial result_valid pulses got %0d exp 0", rv_seen); else passed++;
    checks++; if (color_code !== 2'd0) $display("FAIL partial color_code got %0d exp 0", color_code); else passed++;
    checks++; if (red_count !== 12'd0) $display("FAIL partial red_count got %0d exp 0", red_count); else passed++;
  endtask

  task test_red_frame;
    rv_seen = 0;
    drive(1'b1, 1'b0, 0, 0, 8'd0, 8'd0, 8'd0);
    idle(6);
    checks++; if (rv_seen !== 0) $display("FAIL first_fs result_valid pulses got %0d exp 0", rv_seen); else passed++;
    roi_px(0, 1600, 8'd200, 8'd40, 8'd40);
    frame_end("red", 1'b0, 8'd0, 8'd0, 8'd0, 2'd1, 1600, 0, 0);
  endtask

  task test_grey;
    int ex [7], ey [7];
    logic eh [7];
    ex = '{139, 140, 179, 180, 140, 140, 179};
    ey = '{100, 100, 139, 100,  99, 139, 140};
    eh = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, ex[i], ey[i], 8'd128, 8'd128, 8'd128);
      idle(1);
      @(negedge clk);
      checks++; if (in_roi !== eh[i]) $display("FAIL roi_edge (%0d,%0d) in_roi got %b exp %b", ex[i], ey[i], in_roi, eh[i]); else passed++;
    end
    idle(2);
    roi_hits = 0;
    roi_px(0, 1600, 8'd128, 8'd128, 8'd128);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 139, 100 + i, 8'd255, 8'd0, 8'd0);
      drive(1'b0, 1'b1, 180, 100 + i, 8'd255, 8'd0, 8'd0);
      drive(1'b0, 1'b1, 140 + i, 99, 8'd255, 8'd0, 8'd0);
      drive(1'b0, 1'b1, 140 + i, 140, 8'd255, 8'd0, 8'd0);
    end
    frame_end("grey", 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 0, 0, 0);
    checks++; if (roi_hits !== 1600) $display("FAIL grey in_roi cycles got %0d exp 1600", roi_hits); else passed++;
  endtask

  task test_min_pixels;
    roi_px(0, 300, 8'd40, 8'd200, 8'd40);
    roi_px(300, 1300, 8'd128, 8'd128, 8'd128);
    frame_end("below_min", 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 0, 300, 0);
    roi_px(0, 500, 8'd200, 8'd40, 8'd40);
    roi_px(500, 500, 8'd40, 8'd40, 8'd200);
    frame_end("tie", 1'b0, 8'd0, 8'd0, 8'd0, 2'd1, 500, 0, 500);
  endtask

  task test_margin;
    roi_px(0, 500, 8'd116, 8'd100, 8'd100);
    roi_px(500, 500, 8'd115, 8'd100, 8'd100);
    frame_end("margin", 1'b0, 8'd0, 8'd0, 8'd0, 2'd1, 500, 0, 0);
  endtask

  task test_frame_boundary;
    roi_px(0, 1600, 8'd200, 8'd40, 8'd40);
    frame_end("fs_pixel", 1'b1, 8'd200, 8'd40, 8'd40, 2'd1, 1600, 0, 0);
    frame_end("next_frame", 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1, 0, 0);
  endtask

  task test_saturation;
    roi_px(0, 300, 8'd200, 8'd40, 8'd40);
    frame_end("sat12", 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 300, 0, 0);
    checks++; if (red8 !== 8'd255) $display("FAIL sat8 red_count got %0d exp 255", red8); else passed++;
    checks++; if (code8 !== 2'd0) $display("FAIL sat8 color_code got %0d exp 0", code8); else passed++;
    checks++; if (red8m !== 8'd255) $display("FAIL sat8_min200 red_count got %0d exp 255", red8m); else passed++;
    checks++; if (code8m !== 2'd1) $display("FAIL sat8_min200 color_code got %0d exp 1", code8m); else passed++;
  endtask

  initial begin
    test_reset;
    test_partial_first;
    test_reset;
    test_red_frame;
    test_grey;
    test_min_pixels;
    test_margin;
    test_frame_boundary;
    test_saturation;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/roi_color_classifier.md
Name: roi_color_classifier

Overview:
Consumes the 8-bit-per-channel pixel stream and frame_start produced by the frame-buffer reader. Classifies each valid pixel inside a fixed region of interest (ROI) as red, green, blue or none, and counts each class over one frame. At every frame boundary it publishes the dominant colour and the three per-class counts, qualified by a one-cycle result_valid pulse. Downstream dice/race game logic uses the result; the overlay uses in_roi.

Parameters:
ROI_X0, 140, ROI left column (inclusive)
ROI_Y0, 100, ROI top row (inclusive)
ROI_W, 40, ROI width in pixels
ROI_H, 40, ROI height in pixels
DOM_MARGIN, 16, amount by which a channel must exceed both other channels to classify
MIN_PIXELS, 400, minimum winning count for a non-zero colour_code
CNT_W, 12, counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle frame boundary pulse
pixel_valid  in  1  pixel qualifier
pixel_x  in  10  pixel column
pixel_y  in  10  pixel row
pixel_r8  in  8  red channel
pixel_g8  in  8  green channel
pixel_b8  in  8  blue channel
in_roi  out  1  registered flag: the stage-1 pixel is valid and inside the ROI
color_code  out  2  0=none, 1=red, 2=green, 3=blue; held between results
red_count  out  CNT_W  published red count
green_count  out  CNT_W  published green count
blue_count  out  CNT_W  published blue count
result_valid  out  1  one-cycle pulse when the outputs above update

Behaviour:
- Reset:
  - All outputs, counters, snapshots and pipeline registers go to 0.
  - FSM goes to WAIT_FIRST.
  - Reset asserted mid-frame discards all partial counts and any pending result.
- Stage 1 (registered, +1 cycle):
  - ROI hit = pixel_valid && ROI_X0 <= x < ROI_X0+ROI_W && ROI_Y0 <= y < ROI_Y0+ROI_H.
  - in_roi drives the ROI hit.
  - Class registered as follows. All comparisons use 9-bit arithmetic; no wrap.
    - red if r >= g+DOM_MARGIN and r >= b+DOM_MARGIN;
    - else green if g >= r+DOM_MARGIN and g >= b+DOM_MARGIN;
    - else blue if b >= r+DOM_MARGIN and b >= g+DOM_MARGIN;
    - else none.
  - frame_start is delayed 1 cycle to give fs_d1, aligned with stage 1.
- Stage 2 (accumulate):
  - When a stage-1 pixel is in the ROI and its class is not none, increment that class counter.
  - Counters saturate at 2^CNT_W-1.
- Frame boundary (fs_d1 high):
  - snapshot <= live counters.
  - Live counters <= the contribution of the stage-1 pixel present in that same cycle; that pixel belongs to the new frame.
  - Accumulation never stalls.
- FSM:
  - WAIT_FIRST: on fs_d1, clear the counters and go to ACCUM. No result (the first frame is partial).
  - ACCUM: on fs_d1, take the snapshot and go to DECIDE.
  - DECIDE (1 cycle): winner = max snapshot count. Ties resolve red > green > blue. If the winner count < MIN_PIXELS, or all counts are 0, the code is 0. Go to PUBLISH.
  - PUBLISH (1 cycle): load color_code and the three counts from the snapshot, pulse result_valid, go to ACCUM.
  - fs_d1 arriving in DECIDE/PUBLISH is ignored for sequencing. Its counter clear/snapshot still occurs and overwrites the snapshot only after PUBLISH has loaded it.
- Latency: frame_start high at cycle N gives result_valid high at N+3, exactly one cycle wide.
- Published outputs hold their values until the next PUBLISH.

Test Plan:
- Reset, then frame_start, then a full red ROI frame without a second frame_start -> all outputs 0 and no result_valid.
- Two frame_starts bracketing a frame with 1600 ROI pixels at (200,40,40) -> result_valid at N+3 only; color_code=1, red_count=1600, green_count=blue_count=0.
- ROI pixels at (128,128,128) and outside-ROI pixels at (255,0,0) -> color_code=0 and all counts 0; in_roi high only for the 40x40 window.
- 300 green plus 1300 grey ROI pixels -> color_code=0 (below MIN_PIXELS), green_count=300. Then 500 red plus 500 blue -> color_code=1 (tie priority).
- Margin boundary and frame boundary:
  - (116,100,100) classifies red; (115,100,100) classifies none.
  - A red ROI pixel coincident with frame_start is counted in the new frame's red_count, not the published one.
- With CNT_W=8, 300 red ROI pixels -> red_count=255 and color_code=0 (255 < MIN_PIXELS=400). With MIN_PIXELS=200 -> color_code=1.
